adder16: RTL and testbench



---
 rtl/adder16_pkg.sv | 9 +
 rtl/adder16_rca4.sv | 25 ++
 rtl/adder16.sv | 67 ++++++
 tb/tb_adder16.sv | 96 +++++++++
 4 files changed

// File: rtl/adder16_pkg.sv
// adder16 shared constants.
// Width and block size are fixed here and are not overridable.
package adder16_pkg;

    localparam int ADDER_W = 16;
    localparam int BLK_W   = 4;
    localparam int NUM_BLK = ADDER_W / BLK_W;

endpackage

// File: rtl/adder16_rca4.sv
// 4-bit ripple-carry adder.
// Built from bit-level full-adder equations.
module rca4
    import adder16_pkg::*;
(
    input  logic [BLK_W-1:0] a,
    input  logic [BLK_W-1:0] b,
    input  logic             cin,
    output logic [BLK_W-1:0] s,
    output logic             cout
);

    logic [BLK_W:0] c;

    assign c[0] = cin;

    for (genvar i = 0; i < BLK_W; i++) begin : g_fa
        assign s[i]   = a[i] ^ b[i] ^ c[i];
        assign c[i+1] = (a[i] & b[i])
                      | (c[i] & (a[i] ^ b[i]));
    end

    assign cout = c[BLK_W];

endmodule

// File: rtl/adder16.sv
// Registered 16-bit carry-select adder.
// Result {out_C, out_S} = in_A + in_B + in_C, one cycle later.
module adder16
    import adder16_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic [ADDER_W-1:0] in_A,
    input  logic [ADDER_W-1:0] in_B,
    input  logic               in_C,
    output logic [ADDER_W-1:0] out_S,
    output logic               out_C
);

    logic [NUM_BLK:0]   c;
    logic [ADDER_W-1:0] sum;

    assign c[0] = in_C;

    for (genvar i = 0; i < NUM_BLK; i++) begin : g_blk
        if (i == 0) begin : g_first
            rca4 u_rca (
                .a    (in_A[i*BLK_W +: BLK_W]),
                .b    (in_B[i*BLK_W +: BLK_W]),
                .cin  (c[i]),
                .s    (sum[i*BLK_W +: BLK_W]),
                .cout (c[i+1])
            );
        end else begin : g_sel
            logic [BLK_W-1:0] s0;
            logic [BLK_W-1:0] s1;
            logic             co0;
            logic             co1;

            rca4 u_rca0 (
                .a    (in_A[i*BLK_W +: BLK_W]),
                .b    (in_B[i*BLK_W +: BLK_W]),
                .cin  (1'b0),
                .s    (s0),
                .cout (co0)
            );

            rca4 u_rca1 (
                .a    (in_A[i*BLK_W +: BLK_W]),
                .b    (in_B[i*BLK_W +: BLK_W]),
                .cin  (1'b1),
                .s    (s1),
                .cout (co1)
            );

            // Incoming block carry picks the precomputed result.
            assign sum[i*BLK_W +: BLK_W] = c[i] ? s1 : s0;
            assign c[i+1]                = c[i] ? co1 : co0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_S <= '0;
            out_C <= 1'b0;
        end else begin
            out_S <= sum;
            out_C <= c[NUM_BLK];
        end
    end

endmodule

// File: tb/tb_adder16.sv
// Directed and randomized checks of adder16.
// Each result is checked #1 after the capturing edge.
module tb_adder16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] in_A;
    logic [15:0] in_B;
    logic        in_C;
    logic [15:0] out_S;
    logic        out_C;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    adder16 dut (
        .clk   (clk),
        .rst_n (rst_n),
        .in_A  (in_A),
        .in_B  (in_B),
        .in_C  (in_C),
        .out_S (out_S),
        .out_C (out_C)
    );

    task automatic step(
        input string       tag,
        input logic        r,
        input logic [15:0] a,
        input logic [15:0] b,
        input logic        ci,
        input logic [16:0] exp
    );
        @(negedge clk);
        rst_n = r;
        in_A  = a;
        in_B  = b;
        in_C  = ci;
        @(posedge clk);
        #1;
        n_chk++;
        assert ({out_C, out_S} === exp) else begin
            n_fail++;
            $error("FAIL %s: got %h expected %h",
                   tag, {out_C, out_S}, exp);
        end
    endtask

    initial begin
        logic [15:0] a;
        logic [15:0] b;
        logic        ci;
        logic        r;
        logic [16:0] exp;

        rst_n = 1'b0;
        in_A  = 16'h0;
        in_B  = 16'h0;
        in_C  = 1'b0;

        step("rst0", 0, 16'hFFFF, 16'hFFFF, 1, 17'h00000);
        step("rst1", 0, 16'hFFFF, 16'hFFFF, 1, 17'h00000);

        step("zero",   1, 16'h0000, 16'h0000, 0, 17'h00000);
        step("cin",    1, 16'h0000, 16'h0000, 1, 17'h00001);
        step("one",    1, 16'h0001, 16'h0001, 0, 17'h00002);
        step("prop",   1, 16'hFFFF, 16'h0000, 1, 17'h10000);
        step("max",    1, 16'hFFFF, 16'hFFFF, 0, 17'h1FFFE);
        step("maxc",   1, 16'hFFFF, 16'hFFFF, 1, 17'h1FFFF);
        step("b3carry",1, 16'h0FFF, 16'h0001, 0, 17'h01000);
        step("b1carry",1, 16'h000F, 16'h0001, 0, 17'h00010);
        step("b2carry",1, 16'h00FF, 16'h0001, 0, 17'h00100);
        step("msb",    1, 16'h8000, 16'h8000, 0, 17'h10000);
        step("mix",    1, 16'h1234, 16'h4321, 0, 17'h05555);
        step("mixc",   1, 16'hA5A5, 16'h5A5A, 1, 17'h10000);
        step("nib",    1, 16'h7777, 16'h8888, 0, 17'h0FFFF);

        // Back-to-back random operands with a reset pulse mid-stream.
        for (int i = 0; i < 24; i++) begin
            a   = 16'($urandom);
            b   = 16'($urandom);
            ci  = 1'($urandom);
            r   = (i == 10 || i == 11) ? 1'b0 : 1'b1;
            exp = r ? ({1'b0, a} + {1'b0, b} + {16'h0, ci})
                    : 17'h0;
            step($sformatf("rnd%0d", i), r, a, b, ci, exp);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
